// File: rtl/sram_port0_ctrl_if.sv
// Request/response stream plus macro pin bundle for sram_port0_ctrl.
// Ports: req_* (valid/ready request in), rsp_* (valid/ready read data out), init_done,
//        csb0/web0/wmask0/spare_wen0/addr0/din0 (to macro), dout0 (from macro).
interface sram_port0_ctrl_if #(
    parameter int DATA_WIDTH = 65,
    parameter int ADDR_WIDTH = 11,
    parameter int NUM_WMASKS = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [NUM_WMASKS:0]   req_wmask;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  init_done;
    logic                  csb0;
    logic                  web0;
    logic [NUM_WMASKS-1:0] wmask0;
    logic                  spare_wen0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;

    // Requester and macro side (testbench / surrounding logic).
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready, dout0,
        input  req_ready, rsp_valid, rsp_rdata, init_done,
        input  csb0, web0, wmask0, spare_wen0, addr0, din0
    );

    // Controller side.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready, dout0,
        output req_ready, rsp_valid, rsp_rdata, init_done,
        output csb0, web0, wmask0, spare_wen0, addr0, din0
    );
endinterface

// File: rtl/sram_port0_ctrl.sv
// Purpose: sequences a valid/ready request stream onto a single-port SRAM macro, zero-fills it after reset.
// Latency: read accepted in cycle N -> rsp_valid in N+2; writes produce no response.
// Backpressure: req_ready is a credit check over FIFO occupancy + in-flight read, combinational on rsp_ready.
// Ports: clk0/rst0 plain; bus (slave modport) carries req_*, rsp_*, init_done and the macro pins.
module sram_port0_ctrl #(
    parameter int                    DATA_WIDTH = 65,
    parameter int                    ADDR_WIDTH = 11,
    parameter int                    NUM_WMASKS = 8,
    parameter bit                    INIT_EN    = 1'b1,
    parameter int                    INIT_WORDS = 1024,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    parameter int                    RSP_DEPTH  = 2
) (
    input  logic               clk0,
    input  logic               rst0,
    sram_port0_ctrl_if.slave   bus
);
    localparam int CW = $clog2(RSP_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(INIT_WORDS - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    localparam state_t ST_RESET = INIT_EN ? ST_INIT : ST_RUN;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_init_cnt, w_init_cnt_nxt;
    logic                  r_rd_pending;

    logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];
    logic [CW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [CW:0]           r_count;

    logic                  w_push, w_pop, w_credit_ok, w_req_ready, w_accept;
    logic [CW+1:0]         w_occ;

    logic                  w_csb0, w_web0, w_spare_wen0;
    logic [NUM_WMASKS-1:0] w_wmask0;
    logic [ADDR_WIDTH-1:0] w_addr0;
    logic [DATA_WIDTH-1:0] w_din0;

    // dout0 is only valid on the edge that closes the cycle after a read issue.
    assign w_push = r_rd_pending;
    assign w_pop  = (r_count != '0) && bus.rsp_ready;

    // Slots committed next cycle: stored + in flight, minus whatever leaves now.
    assign w_occ       = {1'b0, r_count} + {{(CW+1){1'b0}}, r_rd_pending} - {{(CW+1){1'b0}}, w_pop};
    assign w_credit_ok = w_occ < (CW+2)'(RSP_DEPTH);

    // Gated by rst0 so the macro is deselected the instant reset asserts.
    assign w_req_ready = (r_state == ST_RUN) && w_credit_ok && !rst0;
    assign w_accept    = bus.req_valid && w_req_ready;

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            r_state      <= ST_RESET;
            r_init_cnt   <= '0;
            r_rd_pending <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_init_cnt   <= w_init_cnt_nxt;
            r_rd_pending <= w_accept && !bus.req_we;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_csb0         = 1'b1;
        w_web0         = 1'b1;
        w_wmask0       = '0;
        w_spare_wen0   = 1'b0;
        w_addr0        = '0;
        w_din0         = '0;
        case (r_state)
            ST_INIT: begin
                w_init_cnt_nxt = r_init_cnt + ADDR_WIDTH'(1);
                if (r_init_cnt == LAST_ADDR) begin
                    w_state_nxt = ST_RUN;
                end
                if (!rst0) begin
                    w_csb0       = 1'b0;
                    w_web0       = 1'b0;
                    w_wmask0     = '1;
                    w_spare_wen0 = 1'b1;
                    w_addr0      = r_init_cnt;
                    w_din0       = INIT_VALUE;
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    w_csb0       = 1'b0;
                    w_web0       = !bus.req_we;
                    w_addr0      = bus.req_addr;
                    w_din0       = bus.req_wdata;
                    w_wmask0     = bus.req_wmask[NUM_WMASKS-1:0];
                    w_spare_wen0 = bus.req_wmask[NUM_WMASKS] && bus.req_we;
                end
            end
            default: w_state_nxt = ST_RESET;
        endcase
    end

    // Response FIFO; the head slot is untouched while stalled, so rsp_rdata holds.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.dout0;
                r_wr_ptr        <= r_wr_ptr + CW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + CW'(1);
            end
            r_count <= r_count + {{CW{1'b0}}, w_push} - {{CW{1'b0}}, w_pop};
        end
    end

    a_no_overflow: assert property (@(posedge clk0) disable iff (rst0)
        !(w_push && (r_count == (CW+1)'(RSP_DEPTH)) && !w_pop));

    assign bus.req_ready  = w_req_ready;
    assign bus.rsp_valid  = (r_count != '0);
    assign bus.rsp_rdata  = r_mem[r_rd_ptr];
    assign bus.init_done  = (r_state == ST_RUN);
    assign bus.csb0       = w_csb0;
    assign bus.web0       = w_web0;
    assign bus.wmask0     = w_wmask0;
    assign bus.spare_wen0 = w_spare_wen0;
    assign bus.addr0      = w_addr0;
    assign bus.din0       = w_din0;
endmodule

// File: tb/tb_sram_port0_ctrl.sv
// Bench for sram_port0_ctrl: behavioural macro model, reference memory + expected-response queue.
module tb_sram_port0_ctrl;
    localparam int DW = 65;
    localparam int AW = 11;
    localparam int NW = 8;
    localparam int WORDS = 1024;

    logic clk0 = 1'b0;
    logic rst0 = 1'b0;
    always #5 clk0 = ~clk0;

    sram_port0_ctrl_if bus ();
    sram_port0_ctrl dut (.clk0(clk0), .rst0(rst0), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_pops   = 0;
    int last_acc_cyc = 0;
    logic last_acc = 1'b0;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data, last_rdata;
    logic [DW-1:0] sram    [WORDS];
    logic [DW-1:0] ref_mem [WORDS];
    logic [DW-1:0] exp_q [$];
    int pop_cyc_q [$];

    function automatic logic [DW-1:0] rnd65();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Macro model: writes land at the issuing edge, read data appears after the edge
    // and is replaced by garbage on the next edge.
    always @(posedge clk0) begin
        if (!bus.csb0 && !bus.web0) begin
            for (int b = 0; b < NW; b++)
                if (bus.wmask0[b]) sram[bus.addr0[9:0]][8*b +: 8] = bus.din0[8*b +: 8];
            if (bus.spare_wen0) sram[bus.addr0[9:0]][64] = bus.din0[64];
            bus.dout0 <= rnd65();
        end else if (!bus.csb0) begin
            bus.dout0 <= sram[bus.addr0[9:0]];
        end else begin
            bus.dout0 <= rnd65();
        end
    end

    // One clock: entered at posedge+1, samples at the negedge, returns at posedge+1.
    task automatic cycle();
        logic [DW-1:0] e;
        @(negedge clk0);
        cyc++;
        if (prev_stall) begin
            chk("hold_valid", DW'(bus.rsp_valid), DW'(1));
            chk("hold_data", bus.rsp_rdata, prev_data);
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("stale_rsp", DW'(bus.rsp_valid), DW'(0));
            end else begin
                e = exp_q.pop_front();
                chk("rsp_data", bus.rsp_rdata, e);
            end
            last_rdata = bus.rsp_rdata;
            n_pops++;
            pop_cyc_q.push_back(cyc);
        end
        prev_stall = bus.rsp_valid && !bus.rsp_ready;
        prev_data  = bus.rsp_rdata;
        last_acc   = bus.req_valid && bus.req_ready;
        if (last_acc) begin
            last_acc_cyc = cyc;
            if (bus.req_we) begin
                for (int b = 0; b < NW; b++)
                    if (bus.req_wmask[b]) ref_mem[bus.req_addr[9:0]][8*b +: 8] = bus.req_wdata[8*b +: 8];
                if (bus.req_wmask[NW]) ref_mem[bus.req_addr[9:0]][64] = bus.req_wdata[64];
            end else begin
                exp_q.push_back(ref_mem[bus.req_addr[9:0]]);
            end
        end
        @(posedge clk0);
        #1;
    endtask

    task automatic send(input logic we, input int addr, input logic [DW-1:0] data, input logic [NW:0] mask);
        int n;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = AW'(addr);
        bus.req_wdata = data;
        bus.req_wmask = mask;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 50);
        if (!last_acc) chk("send_timeout", DW'(bus.req_ready), DW'(1));
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || bus.rsp_valid) && n < 50) begin
            cycle();
            n++;
        end
        chk("drain_empty", DW'(exp_q.size()), DW'(0));
    endtask

    // Assert reset for about a cycle, then check the full init sweep with req_valid held high.
    task automatic reset_and_init();
        rst0 = 1'b1;
        #1;
        chk("rst_now_csb0", DW'(bus.csb0), DW'(1));
        chk("rst_now_rsp_valid", DW'(bus.rsp_valid), DW'(0));
        chk("rst_now_req_ready", DW'(bus.req_ready), DW'(0));
        exp_q.delete();
        prev_stall = 1'b0;
        @(posedge clk0);
        @(negedge clk0);
        chk("rst_rsp_rdata", bus.rsp_rdata, DW'(0));
        chk("rst_init_done", DW'(bus.init_done), DW'(0));
        chk("rst_web0", DW'(bus.web0), DW'(1));
        chk("rst_wmask0", DW'(bus.wmask0), DW'(0));
        chk("rst_spare_wen0", DW'(bus.spare_wen0), DW'(0));
        chk("rst_addr0", DW'(bus.addr0), DW'(0));
        chk("rst_din0", bus.din0, DW'(0));
        rst0 = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = AW'($urandom_range(1023, 0));
        bus.req_wdata = rnd65();
        bus.req_wmask = '1;
        for (int k = 0; k < WORDS; k++) begin
            #1;
            chk("init_csb0", DW'(bus.csb0), DW'(0));
            chk("init_web0", DW'(bus.web0), DW'(0));
            chk("init_wmask0", DW'(bus.wmask0), DW'(8'hFF));
            chk("init_spare", DW'(bus.spare_wen0), DW'(1));
            chk("init_addr0", DW'(bus.addr0), DW'(k));
            chk("init_din0", bus.din0, DW'(0));
            chk("init_req_ready", DW'(bus.req_ready), DW'(0));
            chk("init_done_low", DW'(bus.init_done), DW'(0));
            @(negedge clk0);
        end
        bus.req_valid = 1'b0;
        #1;
        chk("init_done_high", DW'(bus.init_done), DW'(1));
        for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
        @(posedge clk0);
        #1;
    endtask

    initial begin
        int idx, acc, pops0, wr_acc, rd_acc;
        for (int i = 0; i < WORDS; i++) sram[i] = rnd65();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
        bus.rsp_ready = 1'b1;
        #2;
        reset_and_init();

        // Swept array reads back as zero.
        send(1'b0, 5, '0, '0);
        drain();
        chk("init_read5", last_rdata, DW'(0));

        // Full write then immediate read; 2-cycle latency.
        send(1'b1, 3, 65'h1_DEADBEEF_CAFEF00D, 9'h1FF);
        wr_acc = last_acc_cyc;
        send(1'b0, 3, '0, '0);
        rd_acc = last_acc_cyc;
        drain();
        chk("wr_rd_b2b", DW'(rd_acc - wr_acc), DW'(1));
        chk("rd3_data", last_rdata, 65'h1_DEADBEEF_CAFEF00D);
        chk("rd_latency", DW'(pop_cyc_q[$] - rd_acc), DW'(2));

        // Partial byte mask keeps spare bit and upper bytes.
        send(1'b1, 3, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF}, 9'h003);
        send(1'b0, 3, '0, '0);
        drain();
        chk("masked_rd3", last_rdata, 65'h1_DEADBEEF_CAFEFFFF);

        // Credit limit with consumer stalled.
        for (int a = 0; a < 4; a++) send(1'b1, a, rnd65(), 9'h1FF);
        drain();
        pops0 = n_pops;
        bus.rsp_ready = 1'b0;
        idx = 0;
        acc = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = AW'(idx);
        repeat (6) begin
            cycle();
            if (last_acc) begin
                acc++;
                idx++;
                bus.req_addr = AW'(idx);
            end
        end
        chk("stall_accepts", DW'(acc), DW'(2));
        chk("stall_ready", DW'(bus.req_ready), DW'(0));
        bus.rsp_ready = 1'b1;
        for (int n = 0; n < 40 && idx < 4; n++) begin
            cycle();
            if (last_acc) begin
                idx++;
                if (idx < 4) bus.req_addr = AW'(idx);
                else bus.req_valid = 1'b0;
            end
        end
        drain();
        chk("stall_all_rsp", DW'(n_pops - pops0), DW'(4));

        // 16 back-to-back reads with the consumer always ready.
        for (int a = 16; a < 32; a++) send(1'b1, a, rnd65(), 9'h1FF);
        drain();
        pop_cyc_q.delete();
        pops0 = n_pops;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.req_addr = AW'(16 + i);
            chk("b2b_ready", DW'(bus.req_ready), DW'(1));
            cycle();
            chk("b2b_accept", DW'(last_acc), DW'(1));
        end
        drain();
        chk("b2b_count", DW'(n_pops - pops0), DW'(16));
        if (pop_cyc_q.size() >= 16)
            chk("b2b_contig", DW'(pop_cyc_q[$] - pop_cyc_q[pop_cyc_q.size()-16]), DW'(15));

        // Random traffic against the reference.
        repeat (400) begin
            bus.req_valid = ($urandom_range(3, 0) != 0);
            bus.req_we    = $urandom_range(1, 0) == 1;
            bus.req_addr  = AW'($urandom_range(31, 0));
            bus.req_wdata = rnd65();
            bus.req_wmask = 9'($urandom());
            bus.rsp_ready = ($urandom_range(3, 0) != 0);
            cycle();
        end
        drain();

        // Reset with two reads outstanding; nothing stale may emerge afterwards.
        bus.rsp_ready = 1'b0;
        send(1'b0, 3, '0, '0);
        send(1'b0, 4, '0, '0);
        reset_and_init();
        bus.rsp_ready = 1'b1;
        repeat (10) cycle();
        send(1'b0, 3, '0, '0);
        drain();
        chk("post_rst_rd3", last_rdata, DW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
